// File: rtl/bidiag_collect.sv
// bidiag_collect: buffers one 4x4 complex frame and streams its upper-bidiagonal band.
// Define OFFBAND_CHECK_EN to flag frames whose off-band |R|+|I| exceeds OFFBAND_TH.
module bidiag_collect #(
    parameter int BIT_NUM = 18,
    parameter int CHANNEL_SIZE = 16,
    parameter logic [BIT_NUM:0] OFFBAND_TH = 19'd64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic signed [BIT_NUM-1:0] R_i,
    input  logic signed [BIT_NUM-1:0] I_i,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic signed [BIT_NUM-1:0] R_o,
    output logic signed [BIT_NUM-1:0] I_o,
    output logic [2:0]                idx_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      offband_o
);
    localparam int CW = $clog2(CHANNEL_SIZE);
    localparam logic [CW-1:0] LAST_SLOT = CW'(CHANNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx_next;
    logic          store, load, valid_next, err_next;

    logic signed [BIT_NUM-1:0] mem_r [CHANNEL_SIZE];
    logic signed [BIT_NUM-1:0] mem_i [CHANNEL_SIZE];

    // Band element e -> matrix slot: diagonal d0..d3 interleaved with superdiagonal e0..e2
    function automatic logic [CW-1:0] band_slot(input logic [2:0] e);
        case (e)
            3'd0:    return CW'(0);
            3'd1:    return CW'(1);
            3'd2:    return CW'(5);
            3'd3:    return CW'(6);
            3'd4:    return CW'(10);
            3'd5:    return CW'(11);
            default: return CW'(15);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_o;
        store      = 1'b0;
        load       = 1'b0;
        valid_next = valid_o;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    store      = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (valid_i) begin
                    store    = 1'b1;
                    cnt_next = cnt + CW'(1);
                    if (cnt == LAST_SLOT) begin
                        // slot 0 is already stored, so the first element can load now
                        state_next = DRAIN;
                        cnt_next   = '0;
                        idx_next   = 3'd0;
                        load       = 1'b1;
                        valid_next = 1'b1;
                    end
                end else begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                err_next = valid_i;
                if (valid_o && ready_i) begin
                    if (idx_o == 3'd6) begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_o + 3'd1;
                        load     = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            R_o     <= '0;
            I_o     <= '0;
            idx_o   <= '0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
            for (int k = 0; k < CHANNEL_SIZE; k++) begin
                mem_r[k] <= '0;
                mem_i[k] <= '0;
            end
        end else begin
            valid_o <= valid_next;
            err_o   <= err_next;
            idx_o   <= idx_next;
            busy_o  <= (state_next != IDLE);
            if (store) begin
                mem_r[cnt] <= R_i;
                mem_i[cnt] <= I_i;
            end
            if (load) begin
                R_o <= mem_r[band_slot(idx_next)];
                I_o <= mem_i[band_slot(idx_next)];
            end
        end
    end

`ifdef OFFBAND_CHECK_EN
    // Magnitude is one bit wider so that the most negative sample is represented exactly
    function automatic logic [BIT_NUM:0] mag(input logic signed [BIT_NUM-1:0] x);
        logic signed [BIT_NUM:0] xe;
        xe = {x[BIT_NUM-1], x};
        return x[BIT_NUM-1] ? $unsigned(-xe) : $unsigned(xe);
    endfunction

    function automatic logic off_slot(input logic [CW-1:0] s);
        return (s[1:0] != s[3:2]) && ({1'b0, s[1:0]} != ({1'b0, s[3:2]} + 3'd1));
    endfunction

    logic [BIT_NUM:0] sum_mag;
    assign sum_mag = mag(R_i) + mag(I_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            offband_o <= 1'b0;
        end else if (store) begin
            if (cnt == '0)
                offband_o <= 1'b0;
            else if (off_slot(cnt) && (sum_mag > OFFBAND_TH))
                offband_o <= 1'b1;
        end
    end
`else
    assign offband_o = 1'b0;
`endif

endmodule

// File: tb/tb_bidiag_collect.sv
// Directed self-checking bench for bidiag_collect: band order, stalls, aborts,
// protocol errors, reset in DRAIN and (when enabled) the off-band residue flag.
module tb_bidiag_collect;
    logic               clk;
    logic               rst;
    logic               valid_i;
    logic signed [17:0] R_i;
    logic signed [17:0] I_i;
    logic               ready_i;
    logic               valid_o;
    logic signed [17:0] R_o;
    logic signed [17:0] I_o;
    logic [2:0]         idx_o;
    logic               busy_o;
    logic               err_o;
    logic               offband_o;

    int checks = 0;
    int errors = 0;
    int slot_tab[7] = '{0, 1, 5, 6, 10, 11, 15};

    bidiag_collect dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .R_i(R_i), .I_i(I_i),
        .ready_i(ready_i), .valid_o(valid_o), .R_o(R_o), .I_o(I_o),
        .idx_o(idx_o), .busy_o(busy_o), .err_o(err_o), .offband_o(offband_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sends n samples; slot s carries R=s, I=-s unless zero_off zeroes the off-band
    // slots; slot sp_slot (if >=0) carries (sp_r, sp_i) instead.
    task automatic send_frame(input int n, input bit zero_off, input int sp_slot,
                              input int sp_r, input int sp_i);
        for (int s = 0; s < n; s++) begin
            bit inband;
            inband = (s == 0) || (s == 1) || (s == 5) || (s == 6) ||
                     (s == 10) || (s == 11) || (s == 15);
            valid_i = 1'b1;
            if (s == sp_slot) begin
                R_i = 18'(sp_r);
                I_i = 18'(sp_i);
            end else if (zero_off && !inband) begin
                R_i = '0;
                I_i = '0;
            end else begin
                R_i = 18'(s);
                I_i = 18'(-s);
            end
            tick();
            if (s == 0) chk("collect_busy", 32'(busy_o), 1);
            if (s < 15) chk("collect_no_valid", 32'(valid_o), 0);
        end
        valid_i = 1'b0;
        R_i = '0;
        I_i = '0;
    endtask

    // Called right after the last sample edge; optionally injects valid_i at element inj_idx.
    task automatic drain(input bit toggle, input int inj_idx, input int exp_n);
        int  e, n, cyc;
        bit  inj, injd;
        e = 0; n = 0; cyc = 0; injd = 0;
        chk("drain_first_valid", 32'(valid_o), 1);
        while (e < 7 && cyc < 40) begin
            ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            inj = (e == inj_idx) && !injd && valid_o;
            valid_i = inj;
            R_i = 18'sd99;
            I_i = 18'sd77;
            if (valid_o) begin
                n++;
                chk("drain_R", 32'(R_o), slot_tab[e]);
                chk("drain_I", 32'(I_o), -slot_tab[e]);
                chk("drain_idx", 32'(idx_o), e);
                if (ready_i) e++;
            end
            tick();
            cyc++;
            chk("drain_err", 32'(err_o), 32'(inj));
            if (inj) injd = 1'b1;
            valid_i = 1'b0;
        end
        ready_i = 1'b1;
        R_i = '0;
        I_i = '0;
        chk("drain_count", n, exp_n);
        chk("drain_done_valid", 32'(valid_o), 0);
        chk("drain_done_busy", 32'(busy_o), 0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; R_i = '0; I_i = '0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_idx", 32'(idx_o), 0);
        chk("rst_R", 32'(R_o), 0);
        chk("rst_offband", 32'(offband_o), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy_o), 0);

        // Full frame, ready held high
        send_frame(16, 1'b0, -1, 0, 0);
        drain(1'b0, -1, 7);

        // Ready toggling: 1 + 6*2 valid cycles
        send_frame(16, 1'b0, -1, 0, 0);
        drain(1'b1, -1, 13);

        // Frame truncated after 9 samples
        send_frame(9, 1'b0, -1, 0, 0);
        tick();
        chk("abort_err", 32'(err_o), 1);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_valid", 32'(valid_o), 0);
        tick();
        chk("abort_err_single", 32'(err_o), 0);
        tick();
        chk("abort_valid_later", 32'(valid_o), 0);
        send_frame(16, 1'b0, -1, 0, 0);
        drain(1'b0, -1, 7);

        // valid_i during DRAIN at element 3, then on the final handshake
        send_frame(16, 1'b0, -1, 0, 0);
        drain(1'b0, 3, 7);
        send_frame(16, 1'b0, -1, 0, 0);
        drain(1'b0, 6, 7);
        tick();
        chk("exit_no_new_frame", 32'(busy_o), 0);
        chk("exit_err_cleared", 32'(err_o), 0);

        // Reset while element 2 is presented
        send_frame(16, 1'b0, -1, 0, 0);
        chk("rd_idx0", 32'(idx_o), 0);
        tick();
        tick();
        chk("rd_idx2", 32'(idx_o), 2);
        chk("rd_R2", 32'(R_o), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rd_valid", 32'(valid_o), 0);
        chk("rd_busy", 32'(busy_o), 0);
        chk("rd_R", 32'(R_o), 0);
        chk("rd_I", 32'(I_o), 0);
        chk("rd_err", 32'(err_o), 0);
        tick();
        chk("rd_valid_later", 32'(valid_o), 0);

        // Off-band residue: slot 8 with |-40|+|30| = 70 > 64
        send_frame(16, 1'b1, 8, -40, 30);
`ifdef OFFBAND_CHECK_EN
        chk("ob_set_start", 32'(offband_o), 1);
        drain(1'b0, -1, 7);
        chk("ob_set_end", 32'(offband_o), 1);
        send_frame(16, 1'b1, -1, 0, 0);
        chk("ob_clear", 32'(offband_o), 0);
        drain(1'b0, -1, 7);
        // Exactly at threshold is not above it
        send_frame(16, 1'b1, 2, -64, 0);
        chk("ob_at_th", 32'(offband_o), 0);
        drain(1'b0, -1, 7);
        // Most negative sample: magnitude 2^17
        send_frame(16, 1'b1, 13, -131072, 0);
        chk("ob_min_neg", 32'(offband_o), 1);
        drain(1'b0, -1, 7);
`else
        chk("ob_tied_start", 32'(offband_o), 0);
        drain(1'b0, -1, 7);
        chk("ob_tied_end", 32'(offband_o), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bidiag_collect.md
BIDIAG_COLLECT -- requirements
Module: bidiag_collect

Interface
REQ-001 Parameter BIT_NUM, default 18, sample word width of each real/imag component.
REQ-002 Parameter CHANNEL_SIZE, default 16, samples per frame (4x4 matrix, row-major, index = {row,col}).
REQ-003 Parameter OFFBAND_TH, default 19'd64, off-band magnitude threshold (unsigned, BIT_NUM+1 bits).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 valid_i  input  1  upstream sample valid (bidiagonaliser output strobe).
REQ-008 R_i  input  BIT_NUM signed  real component of current sample.
REQ-009 I_i  input  BIT_NUM signed  imaginary component of current sample.
REQ-010 ready_i  input  1  downstream accepts current output element.
REQ-011 valid_o  output  1  output element valid.
REQ-012 R_o  output  BIT_NUM signed  real component of band element.
REQ-013 I_o  output  BIT_NUM signed  imaginary component of band element.
REQ-014 idx_o  output  3  band element number 0..6.
REQ-015 busy_o  output  1  high in COLLECT or DRAIN.
REQ-016 err_o  output  1  one-cycle protocol-error pulse.
REQ-017 offband_o  output  1  frame off-band residue flag (see Configuration).

Function
REQ-018 FSM states IDLE, COLLECT, DRAIN; all outputs registered.
REQ-019 IDLE: valid_i=1 stores sample into slot 0, cnt<=1, -> COLLECT; else remain.
REQ-020 COLLECT: each valid_i=1 cycle stores sample into slot cnt, cnt<=cnt+1; store of slot 15 -> DRAIN, element pointer <=0.
REQ-021 COLLECT with valid_i=0 before slot 15 stored: frame discarded, err_o pulses next cycle, -> IDLE.
REQ-022 DRAIN order: slots 0,1,5,6,10,11,15 (d0,e0,d1,e1,d2,e2,d3) with idx_o 0..6.
REQ-023 First valid_o rises the cycle after slot 15 is written (1-cycle latency).
REQ-024 valid_o, R_o, I_o, idx_o held stable while valid_o=1 and ready_i=0.
REQ-025 Element advances only on valid_o&ready_i; handshake on idx_o=6 -> valid_o<=0, -> IDLE next cycle.
REQ-026 valid_i=1 during DRAIN: sample ignored, err_o pulses one cycle, drain continues unaffected.
REQ-027 New frame accepted only from IDLE; first valid_i in the cycle DRAIN exits is ignored with err_o pulse.
REQ-028 busy_o=1 exactly when state is COLLECT or DRAIN.
REQ-029 Sample storage widths unchanged (BIT_NUM); no arithmetic on band data.

Reset
REQ-030 rst=1 at any clock edge: state<=IDLE, cnt<=0, pointer<=0, all outputs 0, storage cleared to 0.
REQ-031 Reset mid-COLLECT or mid-DRAIN aborts frame; no err_o pulse; valid_o low the following cycle.

Configuration
REQ-032 Macro OFFBAND_CHECK_EN defined: for slots 2,3,4,7,8,9,12,13,14, compute |R|+|I| (BIT_NUM+1 bits unsigned, |-2^(BIT_NUM-1)| = 2^(BIT_NUM-1)) as written.
REQ-033 With OFFBAND_CHECK_EN, offband_o sticks to 1 if any such value > OFFBAND_TH; it is cleared when slot 0 of a new frame is stored and held through DRAIN.
REQ-034 Without OFFBAND_CHECK_EN: no magnitude logic; offband_o tied 0.

Verification
REQ-035 Verification: 16 consecutive valid_i samples R=slot index, I=-slot index, ready_i=1 -> 7 valid_o cycles starting 1 cycle after sample 15, R_o=0,1,5,6,10,11,15, idx_o=0..6, then IDLE.
REQ-036 Verification: same frame, ready_i toggled 1/0 each cycle -> each element held over the stall, 13 valid_o cycles total, order unchanged.
REQ-037 Verification: valid_i drops after 9 samples -> err_o single pulse, valid_o never asserted, next full frame drains correctly.
REQ-038 Verification: valid_i=1 pulse in DRAIN at idx_o=3 -> err_o pulse, remaining elements 3..6 unaltered.
REQ-039 Verification: rst=1 asserted during DRAIN at idx_o=2 -> next cycle valid_o=0, busy_o=0, R_o=I_o=0.
REQ-040 Verification (OFFBAND_CHECK_EN): slot 8 R=-40, I=30, others off-band 0 -> offband_o=1 through DRAIN; next frame with all off-band 0 -> offband_o=0.
